bcd_round_robin_arbiter: RTL and testbench

- Sequential round-robin arbiter sharing one resource among ten requesters.
- Grants are issued as a 4-bit BCD index. This index drives the A inputs of the ttl_7442 one-of-ten decoder, which produces the active-low select lines.
- Idle/gap states present the invalid code 4'b1111, so the 7442 outputs all 1s and no requester is selected.
- Also provides its own decoded Y_bar copy for checking against the 7442.

---
 rtl/bcd_round_robin_arbiter.sv | 138 +++++++++++++
 tb/tb_bcd_round_robin_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_round_robin_arbiter.sv
// Ten-way round-robin arbiter. It issues the winner as a BCD code that drives a
// 7442 one-of-ten decoder, and it mirrors that decode on Y_bar for cross-checking.
module bcd_round_robin_arbiter #(
  parameter int MIN_HOLD   = 2,
  parameter int MAX_HOLD   = 16,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic       Clk,
  input  logic       Clear,
  input  logic       Enable,
  input  logic [9:0] Request_bar,
  input  logic       Release,
  output logic [3:0] Grant_BCD,
  output logic       Grant_valid,
  output logic [9:0] Y_bar,
  output logic       Timeout
);

  // The output delays only describe board-level timing. The RTL drives the
  // outputs with zero delay, so the delay values are only range-checked here.
  if (MIN_HOLD < 1 || MIN_HOLD > 255) begin : g_bad_min_hold
    $error("MIN_HOLD out of range 1..255");
  end
  if (MAX_HOLD < 0 || MAX_HOLD > 255 || (MAX_HOLD != 0 && MAX_HOLD < MIN_HOLD)) begin : g_bad_max_hold
    $error("MAX_HOLD must be 0 or in MIN_HOLD..255");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("output delays must be non-negative");
  end

  localparam logic [3:0] NO_GRANT = 4'b1111;
  localparam logic [9:0] ALL_OFF  = 10'h3FF;
  localparam logic [7:0] MIN_M1   = 8'(MIN_HOLD - 1);
  localparam logic [7:0] MAX_M1   = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2} state_e;

  function automatic logic [9:0] dec7442(input logic [3:0] bcd);
    logic [9:0] y;
    y = ALL_OFF;
    for (int n = 0; n < 10; n++) begin
      if (bcd == 4'(n)) y[n] = 1'b0;
    end
    return y;
  endfunction

  // Scan from the farthest slot to the nearest, so the slot right after ptr is written last and wins.
  function automatic logic [4:0] rr_pick(input logic [9:0] req, input logic [3:0] ptr);
    logic [4:0] res;
    logic [4:0] idx;
    res = 5'd0;
    for (int k = 10; k >= 1; k--) begin
      idx = 5'(ptr) + 5'(k);
      if (idx >= 5'd10) idx = idx - 5'd10;
      if (req[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

  state_e     state_q;
  logic [3:0] ptr_q;
  logic [3:0] grant_q;
  logic [7:0] hold_q;
  logic       valid_q;
  logic [9:0] ybar_q;
  logic       timeout_q;

  logic [9:0] req_s;
  logic [4:0] pick_s;
  logic       rel_ok_s;
  logic       withdraw_s;
  logic       expire_s;

  assign req_s      = ~Request_bar;
  assign pick_s     = rr_pick(req_s, ptr_q);
  assign rel_ok_s   = Release && (hold_q >= MIN_M1);
  // While a grant is active, ybar_q is the one-hot-low mask of the owner.
  assign withdraw_s = ~|(req_s & ~ybar_q);
  assign expire_s   = (MAX_HOLD != 0) && (hold_q == MAX_M1);

  // Arbitration FSM with registered outputs.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q   <= S_IDLE;
      ptr_q     <= 4'd9;
      grant_q   <= NO_GRANT;
      hold_q    <= 8'd0;
      valid_q   <= 1'b0;
      ybar_q    <= ALL_OFF;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_GAP: begin
          timeout_q <= 1'b0;
          if (Enable && pick_s[4]) begin
            state_q <= S_GRANT;
            grant_q <= pick_s[3:0];
            ptr_q   <= pick_s[3:0];
            hold_q  <= 8'd0;
            valid_q <= 1'b1;
            ybar_q  <= dec7442(pick_s[3:0]);
          end else begin
            state_q <= S_IDLE;
            grant_q <= NO_GRANT;
            valid_q <= 1'b0;
            ybar_q  <= ALL_OFF;
          end
        end
        S_GRANT: begin
          hold_q <= (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          if (rel_ok_s || withdraw_s || expire_s) begin
            state_q   <= S_GAP;
            grant_q   <= NO_GRANT;
            valid_q   <= 1'b0;
            ybar_q    <= ALL_OFF;
            timeout_q <= expire_s;
          end else begin
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          grant_q   <= NO_GRANT;
          valid_q   <= 1'b0;
          ybar_q    <= ALL_OFF;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign Grant_BCD   = grant_q;
  assign Grant_valid = valid_q;
  assign Y_bar       = ybar_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_bcd_round_robin_arbiter.sv
// Directed bench for bcd_round_robin_arbiter: a cycle-level behavioural model is compared
// against the DUT outputs on every falling edge, and literal spot checks pin the model.
module tb_bcd_round_robin_arbiter;
  localparam int MIN_HOLD = 2;
  localparam int MAX_HOLD = 16;

  logic       Clk, Clear, Enable, Release;
  logic [9:0] Request_bar;
  logic [3:0] Grant_BCD;
  logic       Grant_valid, Timeout;
  logic [9:0] Y_bar;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the owner (-1 for none), the last served requester, and cycles held so far.
  int m_owner = -1;
  int m_ptr   = 9;
  int m_held  = 0;
  bit m_to    = 1'b0;

  bcd_round_robin_arbiter #(.MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk(Clk), .Clear(Clear), .Enable(Enable), .Request_bar(Request_bar), .Release(Release),
    .Grant_BCD(Grant_BCD), .Grant_valid(Grant_valid), .Y_bar(Y_bar), .Timeout(Timeout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  pick;
    int  n;
    bit  rel, wd, ex;
    pick = -1;
    if (m_owner >= 0) begin
      rel = Release && (m_held >= MIN_HOLD);
      wd  = Request_bar[m_owner];
      ex  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (rel || wd || ex) begin
        m_owner = -1;
        m_to    = ex;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        n = (m_ptr + k) % 10;
        if (pick < 0 && !Request_bar[n]) pick = n;
      end
      if (Enable && pick >= 0) begin
        m_owner = pick;
        m_ptr   = pick;
        m_held  = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk or posedge Clear);
      if (Clear) begin
        m_owner = -1; m_ptr = 9; m_held = 0; m_to = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    logic [9:0] ey;
    forever begin
      @(negedge Clk);
      ey = 10'h3FF;
      if (m_owner >= 0) ey[m_owner] = 1'b0;
      chk("model_bcd",     int'(Grant_BCD),   (m_owner < 0) ? 15 : m_owner);
      chk("model_valid",   int'(Grant_valid), (m_owner < 0) ? 0 : 1);
      chk("model_ybar",    int'(Y_bar),       int'(ey));
      chk("model_timeout", int'(Timeout),     int'(m_to));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_clear();
    Request_bar = 10'h3FF; Release = 1'b0; Enable = 1'b1;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  int seq_exp [10] = '{0, 0, 15, 3, 3, 15, 9, 9, 15, 0};
  int valid_cnt;

  initial begin
    Clear = 1'b1; Enable = 1'b0; Release = 1'b0; Request_bar = 10'h3FF;
    #3;
    chk("reset_bcd",   int'(Grant_BCD),   15);
    chk("reset_valid", int'(Grant_valid), 0);
    chk("reset_ybar",  int'(Y_bar),       10'h3FF);
    chk("reset_to",    int'(Timeout),     0);

    // First grant after reset goes to requester 0, one edge after the request.
    tick();
    Clear = 1'b0; Request_bar = 10'b1111111110; Enable = 1'b1;
    chk("pre_edge_ybar", int'(Y_bar), 10'h3FF);
    tick();
    chk("first_bcd",   int'(Grant_BCD),   0);
    chk("first_ybar",  int'(Y_bar),       10'b1111111110);
    chk("first_valid", int'(Grant_valid), 1);

    // Rotation 0 -> 3 -> 9 -> 0 with a single gap cycle between grants.
    do_clear();
    Request_bar = 10'b0111110110; Release = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rr_seq%0d", i), int'(Grant_BCD), seq_exp[i]);
    end

    // A release before the minimum hold is ignored; a release at hold count 1 ends the grant.
    do_clear();
    Request_bar = 10'b1111011111;
    tick();
    chk("min_grant", int'(Grant_BCD), 5);
    Release = 1'b1;
    tick();
    Release = 1'b0;
    chk("min_early_rel", int'(Grant_BCD), 5);
    Release = 1'b1;
    tick();
    Release = 1'b0;
    chk("min_gap_bcd",   int'(Grant_BCD),   15);
    chk("min_gap_valid", int'(Grant_valid), 0);
    tick();
    chk("min_regrant", int'(Grant_BCD), 5);

    // Timeout after 16 cycles held.
    do_clear();
    Request_bar = 10'b1101111111;
    tick();
    valid_cnt = int'(Grant_valid);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Timeout) break;
      valid_cnt += int'(Grant_valid);
    end
    chk("to_valid_cycles", valid_cnt, 16);
    chk("to_pulse",        int'(Timeout), 1);
    chk("to_gap_bcd",      int'(Grant_BCD), 15);
    tick();
    chk("to_regrant", int'(Grant_BCD), 7);
    chk("to_cleared", int'(Timeout),   0);

    // Withdrawal ends the grant; Enable low blocks the next grant until raised.
    do_clear();
    Request_bar = 10'b1111111011;
    tick();
    chk("wd_grant", int'(Grant_BCD), 2);
    Request_bar = 10'h3FF;
    tick();
    chk("wd_gap", int'(Grant_BCD), 15);
    Enable = 1'b0; Request_bar = 10'b1111101111;
    tick();
    chk("en_idle_bcd", int'(Grant_BCD), 15);
    tick();
    chk("en_idle_ybar", int'(Y_bar), 10'h3FF);
    Enable = 1'b1;
    tick();
    chk("en_grant", int'(Grant_BCD), 4);
    chk("en_ybar",  int'(Y_bar),     10'b1111101111);

    // Clear between edges drops the grant at once; afterwards requester 1 beats 8.
    do_clear();
    Request_bar = 10'b1011111111;
    tick();
    chk("clr_grant8", int'(Grant_BCD), 8);
    #1 Clear = 1'b1;
    #1;
    chk("clr_async_bcd",   int'(Grant_BCD),   15);
    chk("clr_async_valid", int'(Grant_valid), 0);
    chk("clr_async_ybar",  int'(Y_bar),       10'h3FF);
    Request_bar = 10'b1011111101;
    tick();
    Clear = 1'b0;
    tick();
    chk("clr_first_after", int'(Grant_BCD), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
